// File: rtl/ghostbus_pkg.sv
// Shared definitions for the ghostbus command bridge: FSM encoding, default
// bus widths and the read-latency counter sizing rule.
package ghostbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    RWAIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int GB_AW = 24;
  localparam int GB_DW = 32;

  // Counter only ever reaches RD, so it needs clog2(RD+1) bits, at least one.
  function automatic int cnt_width(input int rd);
    return (rd < 1) ? 1 : $clog2(rd + 1);
  endfunction

endpackage

// File: rtl/ghostbus_cmd_bridge_if.sv
// Command/response streams plus the ghostbus port set; the bridge is the
// ghostbus master, the host/design side uses the slave view.
interface ghostbus_cmd_bridge_if
  import ghostbus_pkg::*;
#(
  parameter int AW = GB_AW,
  parameter int DW = GB_DW
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_data;

  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_wen;
  logic          gb_rstb;
  logic [DW-1:0] gb_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, gb_rdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_data,
           gb_addr, gb_wdata, gb_wen, gb_rstb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, gb_rdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_data,
           gb_addr, gb_wdata, gb_wen, gb_rstb
  );

endinterface

// File: rtl/ghostbus_rd_timer.sv
// Read-latency timer: loads 1 on start, counts while run is high and
// saturates at RD; done flags the cycle in which the count equals RD.
module ghostbus_rd_timer #(
  parameter int RD = 8,
  parameter int CW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(1);
    end else if (run) begin
      if (cnt != CW'(RD)) cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign done = run && (cnt == CW'(RD));

endmodule

// File: rtl/ghostbus_cmd_bridge.sv
// Single-outstanding bridge from a valid/ready command stream to ghostbus
// write/read strobes, returning one response per command.
module ghostbus_cmd_bridge
  import ghostbus_pkg::*;
#(
  parameter int AW = GB_AW,
  parameter int DW = GB_DW,
  parameter int RD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 busy,
  ghostbus_cmd_bridge_if.master bus
);

  localparam int CW = cnt_width(RD);

  state_t        state, state_n;
  logic          wr, wr_n;
  logic [AW-1:0] addr, addr_n;
  logic [DW-1:0] wdata, wdata_n;
  logic          wen, wen_n;
  logic          rstb, rstb_n;
  logic          resp_valid, resp_valid_n;
  logic          resp_write, resp_write_n;
  logic [DW-1:0] resp_data, resp_data_n;
  logic          timer_start;
  logic          timer_done;

  ghostbus_rd_timer #(.RD(RD), .CW(CW)) u_rd_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .run   (state == RWAIT),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    wr_n         = wr;
    addr_n       = addr;
    wdata_n      = wdata;
    wen_n        = 1'b0;
    rstb_n       = 1'b0;
    resp_valid_n = resp_valid;
    resp_write_n = resp_write;
    resp_data_n  = resp_data;
    timer_start  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_n = STROBE;
          wr_n    = bus.cmd_write;
          addr_n  = bus.cmd_addr;
          wdata_n = bus.cmd_wdata;
          wen_n   = bus.cmd_write;
          rstb_n  = !bus.cmd_write;
        end
      end
      STROBE: begin
        if (wr) begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_write_n = 1'b1;
          resp_data_n  = '0;
        end else if (RD == 0) begin
          // Zero latency: read data is already valid alongside the strobe.
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_write_n = 1'b0;
          resp_data_n  = bus.gb_rdata;
        end else begin
          state_n     = RWAIT;
          timer_start = 1'b1;
        end
      end
      RWAIT: begin
        if (timer_done) begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_write_n = 1'b0;
          resp_data_n  = bus.gb_rdata;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs; reset clears pending pulses and any queued response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      wen        <= 1'b0;
      rstb       <= 1'b0;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_data  <= '0;
    end else begin
      wr         <= wr_n;
      addr       <= addr_n;
      wdata      <= wdata_n;
      wen        <= wen_n;
      rstb       <= rstb_n;
      resp_valid <= resp_valid_n;
      resp_write <= resp_write_n;
      resp_data  <= resp_data_n;
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign bus.gb_addr   = addr;
  assign bus.gb_wdata  = wdata;
  assign bus.gb_wen    = wen;
  assign bus.gb_rstb   = rstb;
  assign bus.rsp_valid = resp_valid;
  assign bus.rsp_write = resp_write;
  assign bus.rsp_data  = resp_data;

endmodule

// File: tb/tb_ghostbus_cmd_bridge.sv
// Directed and randomized bench for ghostbus_cmd_bridge (RD=8 and RD=0
// instances) with a memory-backed ghostbus slave and an in-order response model.
module tb_ghostbus_cmd_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy8, busy0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ghostbus_cmd_bridge_if #(.AW(24), .DW(32)) bus8 ();
  ghostbus_cmd_bridge_if #(.AW(24), .DW(32)) bus0 ();

  ghostbus_cmd_bridge #(.AW(24), .DW(32), .RD(8)) dut8 (
    .clk(clk), .rst(rst), .busy(busy8), .bus(bus8.master)
  );
  ghostbus_cmd_bridge #(.AW(24), .DW(32), .RD(0)) dut0 (
    .clk(clk), .rst(rst), .busy(busy0), .bus(bus0.master)
  );

  function automatic logic [31:0] pat(input int a);
    if (a == 32) return 32'h0000_0042;
    return 32'hA500_0000 | (32'(a) * 32'h0001_0101);
  endfunction

  // Ghostbus slave for the RD=8 bridge: data valid only exactly 8 cycles after rstb.
  logic [31:0] slave_mem [64];
  logic [63:0] written = '0;
  logic [7:0]  rhist8  = '0;
  logic [31:0] rd0_val = 32'h0;

  always @(posedge clk) begin
    rhist8 <= {rhist8[6:0], bus8.gb_rstb};
    if (bus8.gb_wen) begin
      slave_mem[bus8.gb_addr[5:0]] <= bus8.gb_wdata;
      written[bus8.gb_addr[5:0]]   <= 1'b1;
    end
  end

  assign bus8.gb_rdata = !rhist8[7] ? 32'hFFFF_FFFF :
                         written[bus8.gb_addr[5:0]] ? slave_mem[bus8.gb_addr[5:0]] :
                         pat(int'(bus8.gb_addr[5:0]));
  assign bus0.gb_rdata = bus0.gb_rstb ? rd0_val : 32'hFFFF_FFFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] ref_mem [64];
  logic [32:0] q [$];
  logic [32:0] e;

  initial begin
    int k, cnt, issued, n_rsp, cycles, nwen, nrstb;
    logic acc, take, acc_prev;
    logic [23:0] cur_addr;
    logic [5:0]  a;

    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    bus8.cmd_valid = 0; bus8.cmd_write = 0; bus8.cmd_addr = '0; bus8.cmd_wdata = '0; bus8.rsp_ready = 0;
    bus0.cmd_valid = 0; bus0.cmd_write = 0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0; bus0.rsp_ready = 0;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", bus8.cmd_ready, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_rsp_valid", bus8.rsp_valid, 0);
    chk("rst_rsp_write", bus8.rsp_write, 0);
    chk("rst_rsp_data", bus8.rsp_data, 0);
    chk("rst_gb_addr", bus8.gb_addr, 0);
    chk("rst_gb_wdata", bus8.gb_wdata, 0);
    chk("rst_strobes", {bus8.gb_wen, bus8.gb_rstb}, 0);
    rst = 0;
    tick();

    // Write 0xDEADBEEF to 0x10
    bus8.cmd_valid = 1; bus8.cmd_write = 1; bus8.cmd_addr = 24'h10; bus8.cmd_wdata = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;
    tick();
    bus8.cmd_valid = 0;
    chk("wr_wen_pulse", bus8.gb_wen, 1);
    chk("wr_no_rstb", bus8.gb_rstb, 0);
    chk("wr_gb_addr", bus8.gb_addr, 24'h10);
    chk("wr_gb_wdata", bus8.gb_wdata, 32'hDEAD_BEEF);
    chk("wr_busy", busy8, 1);
    chk("wr_cmd_ready_low", bus8.cmd_ready, 0);
    tick();
    chk("wr_wen_drop", bus8.gb_wen, 0);
    chk("wr_rsp_valid", bus8.rsp_valid, 1);
    chk("wr_rsp_write", bus8.rsp_write, 1);
    chk("wr_rsp_data", bus8.rsp_data, 0);
    bus8.rsp_ready = 1;
    tick();
    bus8.rsp_ready = 0;
    chk("wr_consumed", bus8.rsp_valid, 0);
    chk("wr_idle", bus8.cmd_ready, 1);

    // Read 0x20 with RD=8
    bus8.cmd_valid = 1; bus8.cmd_write = 0; bus8.cmd_addr = 24'h20;
    tick();
    bus8.cmd_valid = 0;
    k = 1; cnt = 0;
    while (!bus8.rsp_valid && k < 50) begin
      cnt += int'(bus8.gb_rstb);
      tick();
      k++;
    end
    chk("rd_latency", k, 10);
    chk("rd_rstb_once", cnt, 1);
    chk("rd_rsp_data", bus8.rsp_data, 32'h42);
    chk("rd_rsp_write", bus8.rsp_write, 0);

    // Backpressure with a write waiting
    bus8.cmd_valid = 1; bus8.cmd_write = 1; bus8.cmd_addr = 24'h04; bus8.cmd_wdata = 32'h1122_3344;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_cmd_ready", bus8.cmd_ready, 0);
      chk("bp_rsp_hold", {bus8.rsp_valid, bus8.rsp_write, bus8.rsp_data}, {1'b1, 1'b0, 32'h42});
      chk("bp_no_wen", bus8.gb_wen, 0);
    end
    bus8.rsp_ready = 1;
    tick();
    bus8.rsp_ready = 0;
    chk("bp_released", {bus8.rsp_valid, bus8.cmd_ready}, 2'b01);
    ref_mem[4] = 32'h1122_3344;
    tick();
    bus8.cmd_valid = 0;
    chk("bp_wen_pulse", {bus8.gb_wen, bus8.gb_addr, bus8.gb_wdata}, {1'b1, 24'h04, 32'h1122_3344});
    tick();
    chk("bp_wen_once", bus8.gb_wen, 0);
    chk("bp_wr_rsp", {bus8.rsp_valid, bus8.rsp_write}, 2'b11);
    bus8.rsp_ready = 1;
    tick();
    bus8.rsp_ready = 0;

    // Zero-latency reads and a write on the RD=0 bridge
    rd0_val = 32'h0000_000C;
    bus0.cmd_valid = 1; bus0.cmd_write = 0; bus0.cmd_addr = 24'h30;
    tick();
    bus0.cmd_valid = 0;
    chk("rd0_rstb", bus0.gb_rstb, 1);
    chk("rd0_not_yet", bus0.rsp_valid, 0);
    tick();
    chk("rd0_rsp", {bus0.rsp_valid, bus0.rsp_write, bus0.rsp_data}, {1'b1, 1'b0, 32'hC});
    bus0.rsp_ready = 1;
    tick();
    rd0_val = 32'h5A5A_0001;
    bus0.rsp_ready = 0;
    bus0.cmd_valid = 1; bus0.cmd_write = 1; bus0.cmd_addr = 24'h31; bus0.cmd_wdata = 32'h0BAD_F00D;
    tick();
    bus0.cmd_valid = 0;
    chk("wr0_wen", {bus0.gb_wen, bus0.gb_rstb, bus0.gb_addr}, {2'b10, 24'h31});
    tick();
    chk("wr0_rsp", {bus0.rsp_valid, bus0.rsp_write, bus0.rsp_data}, {1'b1, 1'b1, 32'h0});
    bus0.rsp_ready = 1;
    tick();
    bus0.rsp_ready = 0;
    bus0.cmd_valid = 1; bus0.cmd_write = 0; bus0.cmd_addr = 24'h32;
    tick();
    bus0.cmd_valid = 0;
    tick();
    chk("rd0b_rsp", {bus0.rsp_valid, bus0.rsp_write, bus0.rsp_data}, {1'b1, 1'b0, 32'h5A5A_0001});
    bus0.rsp_ready = 1;
    tick();
    bus0.rsp_ready = 0;

    // Reset while the RD=8 read has counted to 3
    bus8.cmd_valid = 1; bus8.cmd_write = 0; bus8.cmd_addr = 24'h21;
    tick();
    bus8.cmd_valid = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_rstb", bus8.gb_rstb, 0);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_ready", bus8.cmd_ready, 1);
    cnt = 0;
    bus8.rsp_ready = 1;
    for (int i = 0; i < 15; i++) begin
      cnt += int'(bus8.rsp_valid);
      tick();
    end
    bus8.rsp_ready = 0;
    chk("mid_rst_no_rsp", cnt, 0);
    bus8.cmd_valid = 1; bus8.cmd_write = 0; bus8.cmd_addr = 24'h20;
    tick();
    bus8.cmd_valid = 0;
    k = 1;
    while (!bus8.rsp_valid && k < 50) begin
      tick();
      k++;
    end
    chk("post_rst_latency", k, 10);
    chk("post_rst_data", bus8.rsp_data, 32'h42);
    bus8.rsp_ready = 1;
    tick();
    bus8.rsp_ready = 0;

    // Randomized back-to-back mix against an in-order response model
    issued = 0; n_rsp = 0; cycles = 0; nwen = 0; nrstb = 0;
    acc_prev = 0; cur_addr = 24'h20;
    while ((issued < 200 || q.size() != 0) && cycles < 20000) begin
      chk("rand_wen_rstb_excl", bus8.gb_wen & bus8.gb_rstb, 0);
      if (busy8) chk("rand_addr_stable", bus8.gb_addr, cur_addr);
      nwen  += int'(bus8.gb_wen);
      nrstb += int'(bus8.gb_rstb);
      if (!bus8.cmd_valid || acc_prev) begin
        if (issued < 200 && $urandom_range(0, 3) != 0) begin
          bus8.cmd_valid = 1;
          bus8.cmd_write = 1'($urandom_range(0, 1));
          bus8.cmd_addr  = 24'($urandom_range(0, 63));
          bus8.cmd_wdata = $urandom;
        end else begin
          bus8.cmd_valid = 0;
        end
      end
      bus8.rsp_ready = ($urandom_range(0, 2) != 0);
      acc  = bus8.cmd_valid && bus8.cmd_ready;
      take = bus8.rsp_valid && bus8.rsp_ready;
      if (take) begin
        chk("rand_rsp_expected", (q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          n_rsp++;
          chk("rand_rsp_write", bus8.rsp_write, e[32]);
          chk("rand_rsp_data", bus8.rsp_data, e[31:0]);
          chk("rand_strobe_once", e[32] ? nwen : nrstb, 1);
          chk("rand_other_strobe", e[32] ? nrstb : nwen, 0);
          nwen = 0; nrstb = 0;
        end
      end
      if (acc) begin
        a = bus8.cmd_addr[5:0];
        if (bus8.cmd_write) begin
          q.push_back({1'b1, 32'h0});
          ref_mem[a] = bus8.cmd_wdata;
        end else begin
          q.push_back({1'b0, ref_mem[a]});
        end
        cur_addr = bus8.cmd_addr;
        issued++;
      end
      acc_prev = acc;
      tick();
      cycles++;
    end
    bus8.cmd_valid = 0;
    bus8.rsp_ready = 0;
    chk("rand_rsp_count", n_rsp, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
